// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage access controller for a variable-latency memory port
// Latches one access in IDLE, waits for ack or timeout in BUSY, releases the pipeline in DONE.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       load_type_MEM,
  input  logic [3:0]       cache_write_en_MEM,
  input  logic [31:0]      addr_MEM,
  input  logic [31:0]      wdata_MEM,
  output logic             mem_req,
  output logic [3:0]       mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             stall_mem,
  output logic [31:0]      load_data_WB,
  output logic             timeout_err,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_CYC = 8'(TIMEOUT - 1);

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       we_q;
  logic [2:0]       ltype_q;
  logic             was_load_q;
  logic [7:0]       cyc_q;
  logic             mem_req_q;
  logic             timeout_err_q;
  logic [31:0]      load_data_q;
  logic [CNT_W-1:0] load_cnt_q;
  logic [CNT_W-1:0] store_cnt_q;
  logic [CNT_W-1:0] timeout_cnt_q;

  logic is_load;
  logic is_store;
  logic req;

  assign is_load  = (load_type_MEM >= 3'd1) && (load_type_MEM <= 3'd5);
  assign is_store = |cache_write_en_MEM;
  assign req      = is_load | is_store;

  function automatic logic [31:0] extend(input logic [2:0] ltype, input logic [1:0] b,
                                         input logic [31:0] rdata);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = rdata >> {b, 3'b000};
    half = b[1] ? rdata[31:16] : rdata[15:0];
    case (ltype)
      3'd1:    extend = {{24{sh[7]}}, sh[7:0]};
      3'd2:    extend = {{16{half[15]}}, half};
      3'd3:    extend = rdata;
      3'd4:    extend = {24'd0, sh[7:0]};
      3'd5:    extend = {16'd0, half};
      default: extend = 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= '0;
      ltype_q       <= '0;
      was_load_q    <= 1'b0;
      cyc_q         <= '0;
      mem_req_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      load_data_q   <= '0;
      load_cnt_q    <= '0;
      store_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            // A load wins over a simultaneous store, so its byte enables are dropped.
            addr_q     <= addr_MEM;
            wdata_q    <= wdata_MEM;
            we_q       <= is_load ? 4'd0 : cache_write_en_MEM;
            ltype_q    <= load_type_MEM;
            was_load_q <= is_load;
            cyc_q      <= '0;
            mem_req_q  <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          cyc_q <= cyc_q + 8'd1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
            if (was_load_q) begin
              load_data_q <= extend(ltype_q, addr_q[1:0], mem_rdata);
              load_cnt_q  <= load_cnt_q + CNT_W'(1);
            end else begin
              store_cnt_q <= store_cnt_q + CNT_W'(1);
            end
          end else if (cyc_q == LAST_CYC) begin
            mem_req_q     <= 1'b0;
            state_q       <= DONE;
            load_data_q   <= '0;
            timeout_err_q <= 1'b1;
            timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_mem    = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign mem_req      = mem_req_q;
  assign mem_we       = we_q;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_wdata    = wdata_q;
  assign load_data_WB = load_data_q;
  assign timeout_err  = timeout_err_q;
  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  load_type_MEM;
  logic [3:0]  cache_write_en_MEM;
  logic [31:0] addr_MEM;
  logic [31:0] wdata_MEM;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_mem;
  logic [31:0] load_data_WB;
  logic        timeout_err;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic [31:0] timeout_cnt;

  int compared;
  int mismatched;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .load_type_MEM      (load_type_MEM),
    .cache_write_en_MEM (cache_write_en_MEM),
    .addr_MEM           (addr_MEM),
    .wdata_MEM          (wdata_MEM),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata),
    .stall_mem          (stall_mem),
    .load_data_WB       (load_data_WB),
    .timeout_err        (timeout_err),
    .load_cnt           (load_cnt),
    .store_cnt          (store_cnt),
    .timeout_cnt        (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_type_MEM      = 3'd0;
    cache_write_en_MEM = 4'd0;
    addr_MEM           = 32'd0;
    wdata_MEM          = 32'd0;
  endtask

  // Load acked on the first BUSY cycle; checks the extended result in DONE.
  task automatic one_load(input string tag, input logic [2:0] lt, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    load_type_MEM = lt;
    addr_MEM      = a;
    #1;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    check(tag, load_data_WB, exp);
    idle_inputs();
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    idle_inputs();
    tick();
    tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall_mem}, 32'd0);
    check("rst_load_data", load_data_WB, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
    check("rst_cnts", load_cnt | store_cnt | timeout_cnt, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_no_stall", {31'd0, stall_mem}, 32'd0);

    // LW with ack two cycles after mem_req rises: stall spans four cycles
    load_type_MEM = 3'd3;
    addr_MEM      = 32'h100;
    #1;
    check("lw_stall_c1", {31'd0, stall_mem}, 32'd1);
    check("lw_req_c1", {31'd0, mem_req}, 32'd0);
    tick();
    check("lw_req_c2", {31'd0, mem_req}, 32'd1);
    check("lw_stall_c2", {31'd0, stall_mem}, 32'd1);
    check("lw_addr_c2", mem_addr, 32'h100);
    check("lw_we_c2", {28'd0, mem_we}, 32'd0);
    tick();
    check("lw_stall_c3", {31'd0, stall_mem}, 32'd1);
    check("lw_addr_c3", mem_addr, 32'h100);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_stall_c4", {31'd0, stall_mem}, 32'd1);
    check("lw_we_c4", {28'd0, mem_we}, 32'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    check("lw_done_stall", {31'd0, stall_mem}, 32'd0);
    check("lw_done_req", {31'd0, mem_req}, 32'd0);
    check("lw_data", load_data_WB, 32'hDEADBEEF);
    check("lw_load_cnt", load_cnt, 32'd1);
    idle_inputs();
    tick();
    check("lw_idle_stall", {31'd0, stall_mem}, 32'd0);
    check("lw_data_held", load_data_WB, 32'hDEADBEEF);

    one_load("lb_a3", 3'd1, 32'h3, 32'h80817F90, 32'hFFFFFF80);
    one_load("lbu_a1", 3'd4, 32'h1, 32'h80817F90, 32'h0000007F);
    one_load("lh_a2", 3'd2, 32'h2, 32'h80817F90, 32'hFFFF8081);
    one_load("lhu_a0", 3'd5, 32'h0, 32'h80817F90, 32'h00007F90);
    check("ext_load_cnt", load_cnt, 32'd5);

    // Store acked on first BUSY cycle: two-cycle stall
    cache_write_en_MEM = 4'b1100;
    wdata_MEM          = 32'hAABB0000;
    addr_MEM           = 32'h206;
    #1;
    check("st_stall_c1", {31'd0, stall_mem}, 32'd1);
    tick();
    check("st_we", {28'd0, mem_we}, 32'hC);
    check("st_addr", mem_addr, 32'h204);
    check("st_wdata", mem_wdata, 32'hAABB0000);
    check("st_stall_c2", {31'd0, stall_mem}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("st_done_stall", {31'd0, stall_mem}, 32'd0);
    check("st_store_cnt", store_cnt, 32'd1);
    check("st_load_cnt", load_cnt, 32'd5);
    idle_inputs();
    tick();

    // Load that never gets an ack times out after TIMEOUT=4 BUSY cycles
    load_type_MEM = 3'd3;
    addr_MEM      = 32'h40;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_req_%0d", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("to_terr_%0d", i), {31'd0, timeout_err}, 32'd0);
    end
    tick();
    check("to_done_req", {31'd0, mem_req}, 32'd0);
    check("to_terr", {31'd0, timeout_err}, 32'd1);
    check("to_data", load_data_WB, 32'd0);
    check("to_cnt", timeout_cnt, 32'd1);
    check("to_stall", {31'd0, stall_mem}, 32'd0);
    idle_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    tick();
    check("to_terr_once", {31'd0, timeout_err}, 32'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    check("late_ack_load_cnt", load_cnt, 32'd5);
    check("late_ack_store_cnt", store_cnt, 32'd1);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_data", load_data_WB, 32'd0);

    // Load and store together: load wins, byte enables suppressed
    load_type_MEM      = 3'd3;
    cache_write_en_MEM = 4'hF;
    wdata_MEM          = 32'hFFFFFFFF;
    addr_MEM           = 32'h300;
    #1;
    tick();
    check("ls_we", {28'd0, mem_we}, 32'd0);
    check("ls_addr", mem_addr, 32'h300);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    check("ls_load_cnt", load_cnt, 32'd6);
    check("ls_store_cnt", store_cnt, 32'd1);
    check("ls_data", load_data_WB, 32'h12345678);
    idle_inputs();
    tick();

    // Reset asserted mid-BUSY abandons the access silently
    load_type_MEM = 3'd3;
    addr_MEM      = 32'h80;
    #1;
    tick();
    check("rb_req_busy", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rb_req", {31'd0, mem_req}, 32'd0);
    check("rb_terr", {31'd0, timeout_err}, 32'd0);
    check("rb_load_cnt", load_cnt, 32'd0);
    check("rb_store_cnt", store_cnt, 32'd0);
    check("rb_to_cnt", timeout_cnt, 32'd0);
    check("rb_data", load_data_WB, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rb_quiet_%0d", i), {31'd0, timeout_err | mem_req}, 32'd0);
    end
    check("rb_to_cnt_after", timeout_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage responder that consumes the EX/MEM control signals `load_type_MEM` and `cache_write_en_MEM` and performs the data access on a variable-latency memory port.
- While an access is outstanding it asserts `stall_mem`; the hazard unit turns this into `bubbleM` and upstream bubbles.
- On completion it returns sign- or zero-extended load data to the WB path and keeps load/store/timeout statistics.

Parameters:
- TIMEOUT, 64: BUSY cycles without `mem_ack` before the access is abandoned; legal range 2..255.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- load_type_MEM  in  3  load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none.
- cache_write_en_MEM  in  4  byte write enables; nonzero means store.
- addr_MEM  in  32  byte address from the ALU result.
- wdata_MEM  in  32  store data, already lane-aligned.
- mem_req  out  1  request valid to memory.
- mem_we  out  4  byte enables, held stable while `mem_req`=1.
- mem_addr  out  32  word address; bits [1:0] are forced to 0.
- mem_wdata  out  32  store data.
- mem_ack  in  1  one-cycle completion strobe from memory.
- mem_rdata  in  32  read word; valid only when `mem_ack`=1.
- stall_mem  out  1  MEM stage must hold.
- load_data_WB  out  32  extended load result.
- timeout_err  out  1  one-cycle pulse when an access is abandoned.
- load_cnt  out  CNT_W  completed loads.
- store_cnt  out  CNT_W  completed stores.
- timeout_cnt  out  CNT_W  abandoned accesses.

Behaviour:
- Reset (`rst_n`=0 at a rising edge):
  - State returns to IDLE.
  - All outputs and registers clear to 0, including counters, `load_data_WB`, `mem_req` and the BUSY counter.
  - Reset asserted mid-BUSY abandons the access silently: no counter increment, no error pulse.
- Request definition: `req = (load_type_MEM in 1..5) | (cache_write_en_MEM != 0)`.
- Load and store together: load takes priority, and `mem_we` is driven 0.
- States:
  - IDLE:
    - `stall_mem = req`, combinational.
    - If `req`: latch addr, wdata, byte enables (forced to 0 for a load), load type and a `was_load` flag; clear the cycle counter; go to BUSY.
  - BUSY:
    - `mem_req`=1 and `stall_mem`=1.
    - `mem_addr`, `mem_we` and `mem_wdata` come from the latched values and stay constant.
    - Cycle counter increments each cycle.
    - If `mem_ack`: go to DONE. For a load, register the extended `mem_rdata` into `load_data_WB` and increment `load_cnt`; otherwise increment `store_cnt`.
    - Else if the counter reaches TIMEOUT-1: go to DONE, set `load_data_WB`=0, pulse `timeout_err` in the DONE cycle, increment `timeout_cnt`.
    - `mem_ack` in the same cycle as the timeout threshold: the ack wins.
  - DONE:
    - `stall_mem`=0 and `mem_req`=0, so the pipeline advances at the next edge.
    - Next state is always IDLE. A new request is only recognised in IDLE, so the same instruction is never re-issued.
- Access cost: minimum 3 cycles (IDLE, BUSY with ack, DONE).
- `mem_ack` outside BUSY is ignored.
- `load_data_WB` holds its value until the next completed load or timeout.
- Extension, with `b = addr[1:0]` and `h = addr[1]`:
  - LB: sign-extend byte b.
  - LBU: zero-extend byte b.
  - LH: sign-extend halfword h.
  - LHU: zero-extend halfword h.
  - LW: whole word, `addr[1:0]` ignored.
  - Misaligned LH/LW are not trapped.
- Counters wrap modulo 2^CNT_W with no saturation.

Test Plan:
- Reset with `rst_n`=0 for 2 cycles -> all outputs 0, state IDLE, `stall_mem`=0 with no request.
- LW at addr 0x100, `mem_ack` returned 2 cycles after `mem_req` rises with `mem_rdata`=0xDEADBEEF:
  - `stall_mem` high for 4 cycles.
  - `mem_addr`=0x100 and `mem_we`=0 for the whole request.
  - Then `load_data_WB`=0xDEADBEEF and `load_cnt`=1.
- `mem_rdata`=0x8081_7F90 returned for each extension case:
  - LB at addr 0x3 -> 0xFFFFFF80.
  - LBU at addr 0x1 -> 0x0000007F.
  - LH at addr 0x2 -> 0xFFFF8081.
  - LHU at addr 0x0 -> 0x00007F90.
- Store with `cache_write_en_MEM`=4'b1100, `wdata_MEM`=0xAABB0000, addr 0x206, ack on the first BUSY cycle:
  - `mem_we`=4'b1100, `mem_addr`=0x204.
  - `store_cnt`=1, `load_cnt` unchanged.
  - Stall lasts exactly 2 cycles.
- TIMEOUT=4, load with no ack:
  - `mem_req` high exactly 4 cycles.
  - Then `timeout_err` pulses once, `load_data_WB`=0, `timeout_cnt`=1, `stall_mem` drops.
  - Ack arriving later is ignored.
- Load plus store request with `load_type_MEM`=3 and `cache_write_en_MEM`=4'hF -> `mem_we`=0 and `load_cnt` increments.
- Reset pulsed during BUSY -> `mem_req`=0 next cycle, all counters 0, no `timeout_err`.
